// File: rtl/inst_align_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_align_buffer
// Brief    : RV32IC fetch realignment buffer, splits fetched words into
//            16/32-bit instructions with PC, handles halfword redirects.
// Revision : 1.0
// ============================================================================
module inst_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_rvalid,
  input  logic [31:0] fetch_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);

  localparam logic [31:0] C_RESET_BUF_PC   = RESET_PC & ~32'h1;
  localparam logic [31:0] C_RESET_FETCH_PC = RESET_PC & ~32'h3;

  logic [15:0] hw [4];
  logic [2:0]  hw_cnt;
  logic [31:0] buf_pc;
  logic [31:0] fetch_pc;
  logic        outstanding;
  logic        kill;
  logic        skip_lo;

  logic        is_c;
  logic        avail;
  logic        valid_int;
  logic        fire;
  logic        req_int;
  logic        accept;
  logic [2:0]  pop_n;
  logic [2:0]  app_n;
  logic [2:0]  kept;
  logic [2:0]  cnt_nxt;
  logic [15:0] shifted [4];
  logic [15:0] hw_nxt  [4];

  always_comb begin
    is_c      = (hw[0][1:0] != 2'b11);
    avail     = is_c ? (hw_cnt >= 3'd1) : (hw_cnt >= 3'd2);
    valid_int = !redirect && avail;
    fire      = valid_int && inst_ready;
    pop_n     = !fire ? 3'd0 : (is_c ? 3'd1 : 3'd2);
    req_int   = !outstanding && (hw_cnt <= 3'd2) && !redirect;
    accept    = fetch_rvalid && !kill;
    app_n     = !accept ? 3'd0 : (skip_lo ? 3'd1 : 3'd2);

    for (int i = 0; i < 4; i++) shifted[i] = 16'h0;
    case (pop_n)
      3'd1: begin
        shifted[0] = hw[1];
        shifted[1] = hw[2];
        shifted[2] = hw[3];
      end
      3'd2: begin
        shifted[0] = hw[2];
        shifted[1] = hw[3];
      end
      default: begin
        for (int i = 0; i < 4; i++) shifted[i] = hw[i];
      end
    endcase

    // Pop happens first, so the incoming halfwords land right after what remains.
    kept = hw_cnt - pop_n;
    for (int i = 0; i < 4; i++) begin
      hw_nxt[i] = shifted[i];
      if (app_n != 3'd0 && 3'(i) == kept)
        hw_nxt[i] = skip_lo ? fetch_rdata[31:16] : fetch_rdata[15:0];
      if (app_n == 3'd2 && 3'(i) == kept + 3'd1)
        hw_nxt[i] = fetch_rdata[31:16];
    end
    cnt_nxt = kept + app_n;
  end

  assign fetch_req  = rst_n && req_int;
  assign fetch_addr = rst_n ? fetch_pc : 32'h0;
  assign inst_valid = rst_n && valid_int;
  assign inst       = !rst_n ? 32'h0 : (is_c ? {16'h0, hw[0]} : {hw[1], hw[0]});
  assign inst_pc    = rst_n ? buf_pc : 32'h0;
  assign inst_is_c  = rst_n && is_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hw[i] <= 16'h0;
      hw_cnt      <= 3'd0;
      buf_pc      <= C_RESET_BUF_PC;
      fetch_pc    <= C_RESET_FETCH_PC;
      skip_lo     <= RESET_PC[1];
      outstanding <= 1'b0;
      kill        <= 1'b0;
    end else if (redirect) begin
      hw_cnt      <= 3'd0;
      buf_pc      <= redirect_pc & ~32'h1;
      fetch_pc    <= redirect_pc & ~32'h3;
      skip_lo     <= redirect_pc[1];
      // An in-flight request still owes a response; mark it for discard.
      outstanding <= outstanding && !fetch_rvalid;
      kill        <= outstanding && !fetch_rvalid;
    end else begin
      for (int i = 0; i < 4; i++) hw[i] <= hw_nxt[i];
      hw_cnt <= cnt_nxt;
      buf_pc <= buf_pc + {28'h0, pop_n, 1'b0};
      if (fetch_rvalid) begin
        outstanding <= 1'b0;
        kill        <= 1'b0;
        if (!kill) skip_lo <= 1'b0;
      end
      if (req_int) begin
        fetch_pc    <= fetch_pc + 32'd4;
        outstanding <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_align_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_inst_align_buffer
// Brief    : Directed self-checking bench for inst_align_buffer.
// Revision : 1.0
// ============================================================================
module tb_inst_align_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_rvalid = 1'b0;
  logic [31:0] fetch_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_c;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int epoch = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  inst_align_buffer #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_is_c    (inst_is_c)
  );

  always @(negedge rst_n) epoch = epoch + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: captures a request at the negedge before the issuing edge, answers
  // mem_lat cycles later; responses straddling a reset are dropped.
  initial begin : responder
    logic [31:0] a;
    int ep;
    forever begin
      @(negedge clk);
      if (rst_n && fetch_req) begin
        a  = fetch_addr;
        ep = epoch;
        @(posedge clk);
        repeat (mem_lat) @(posedge clk);
        #1;
        if (ep == epoch && rst_n) begin
          fetch_rvalid = 1'b1;
          fetch_rdata  = rd(a);
          @(posedge clk);
          #1;
          fetch_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic get_inst(input string tag, input logic [31:0] ei,
                          input logic [31:0] ep, input logic ec);
    int n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(inst_valid), 32'h1);
    if (inst_valid) begin
      check({tag, "_inst"}, inst, ei);
      check({tag, "_pc"}, inst_pc, ep);
      check({tag, "_isc"}, 32'(inst_is_c), 32'(ec));
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    check("redir_req", 32'(fetch_req), 32'h0);
    check("redir_valid", 32'(inst_valid), 32'h0);
    step();
    redirect = 1'b0;
  endtask

  logic [31:0] t5_inst [8] = '{32'h0101, 32'h0105, 32'h0013, 32'h010D,
                               32'h0093, 32'h0111, 32'h0115, 32'h0119};
  logic [31:0] t5_pc   [8] = '{32'h200, 32'h202, 32'h204, 32'h208,
                               32'h20A, 32'h20E, 32'h210, 32'h212};
  logic        t5_c    [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int n;
    // 1: reset and first 32-bit instruction
    repeat (3) step();
    check("rst_req", 32'(fetch_req), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    mem[32'h0] = 32'h0000_0013;
    rst_n = 1'b1;
    #1;
    check("t1_req", 32'(fetch_req), 32'h1);
    check("t1_addr", fetch_addr, 32'h0);
    step();
    check("t1_lat0", 32'(inst_valid), 32'h0);
    step();
    check("t1_lat1", 32'(inst_valid), 32'h1);
    get_inst("t1", 32'h13, 32'h0, 1'b0);

    // 2: two compressed halves
    mem[32'h0] = 32'h4505_0505;
    do_redirect(32'h0);
    get_inst("t2a", 32'h0505, 32'h0, 1'b1);
    get_inst("t2b", 32'h4505, 32'h2, 1'b1);

    // 3: 32-bit instruction straddling a word boundary
    mem[32'h0] = 32'h0013_0001;
    mem[32'h4] = 32'hABCD_0000;
    do_redirect(32'h0);
    get_inst("t3a", 32'h0001, 32'h0, 1'b1);
    get_inst("t3b", 32'h0000_0013, 32'h2, 1'b0);

    // 4: redirect with an outstanding request; stale word must vanish
    mem_lat = 2;
    mem[32'h0]   = 32'hFFFF_FFFF;
    mem[32'h104] = 32'h1234_0001;
    mem[32'h108] = 32'h0000_0013;
    do_redirect(32'h0);
    n = 0;
    while (!fetch_req && n < 20) begin
      step();
      n++;
    end
    step();
    do_redirect(32'h107);
    check("t4_addr", fetch_addr, 32'h104);
    get_inst("t4a", 32'h1234, 32'h106, 1'b1);
    get_inst("t4b", 32'h0000_0013, 32'h108, 1'b0);

    // 5: decode stall fills the buffer, then drains in order
    mem_lat = 0;
    mem[32'h200] = 32'h0105_0101;
    mem[32'h204] = 32'h0000_0013;
    mem[32'h208] = 32'h0093_010D;
    mem[32'h20C] = 32'h0111_0000;
    mem[32'h210] = 32'h0119_0115;
    do_redirect(32'h200);
    repeat (12) step();
    check("t5_cnt", 32'(dut.hw_cnt), 32'h4);
    check("t5_req", 32'(fetch_req), 32'h0);
    for (int i = 0; i < 8; i++)
      get_inst($sformatf("t5_%0d", i), t5_inst[i], t5_pc[i], t5_c[i]);

    // 6: asynchronous reset with a request in flight
    mem_lat = 3;
    mem[32'h300] = 32'h0105_0101;
    do_redirect(32'h300);
    n = 0;
    while (!(inst_valid && dut.outstanding) && n < 30) begin
      step();
      n++;
    end
    check("t6_pre", {30'h0, inst_valid, dut.outstanding}, 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(inst_valid), 32'h0);
    check("t6_req", 32'(fetch_req), 32'h0);
    check("t6_inst", inst, 32'h0);
    mem[32'h0] = 32'h0109_0001;
    mem_lat = 0;
    repeat (6) step();
    rst_n = 1'b1;
    #1;
    check("t6_rreq", 32'(fetch_req), 32'h1);
    check("t6_raddr", fetch_addr, 32'h0);
    get_inst("t6a", 32'h0001, 32'h0, 1'b1);
    get_inst("t6b", 32'h0109, 32'h2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
